// File: rtl/engine_result_reader_pkg.sv
// Shared constants and helpers for the engine result reader.
// Mirrors the sha256 engine encodings (thread states, memory layout).
package engine_result_reader_pkg;

    localparam int N_THREADS        = 8;
    localparam int N_THREADS_MSB    = (N_THREADS > 1) ? $clog2(N_THREADS) - 1 : 0;
    localparam int THREAD_STATE_MSB = 1;
    localparam int MEM_TOTAL_MSB    = N_THREADS_MSB + 5;
    localparam int DATA_W           = 32;
    localparam int RESULT_WORDS     = 8;
    localparam int RESULT_OFFSET    = 0;

    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_NONE   = 2'd0;
    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_WR_RDY = 2'd1;
    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_BUSY   = 2'd2;
    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_RD_RDY = 2'd3;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_HDR,
        ST_RD,
        ST_RELEASE
    } rd_state_t;

    typedef logic [N_THREADS_MSB:0] thread_num_t;

    // Thread index successor, wrapping at the last engine thread.
    function automatic thread_num_t next_thread(thread_num_t t);
        return (32'(t) == 32'(N_THREADS - 1)) ? '0 : t + 1'b1;
    endfunction

    // Header word: result length in the upper half, thread number in the lower half.
    function automatic logic [DATA_W-1:0] header_word(thread_num_t t);
        return (32'(RESULT_WORDS) << 16) | 32'(t);
    endfunction

endpackage

// File: rtl/engine_result_reader_if.sv
// Bus bundle between the result reader (master) and the engine/memory/consumer side (slave).
interface engine_result_reader_if;
    import engine_result_reader_pkg::*;

    logic [N_THREADS_MSB:0]    ts_num4;
    logic [THREAD_STATE_MSB:0] ts_rd4;
    logic [THREAD_STATE_MSB:0] ts_wr4;
    logic                      ts_wr_en4;
    logic                      mem_rd_cpu_request;
    logic [MEM_TOTAL_MSB:0]    mem_rd_addr_cpu;
    logic [DATA_W-1:0]         mem_dout;
    logic                      mem_rd_cpu_valid;
    logic [DATA_W-1:0]         dout;
    logic                      dout_valid;
    logic                      dout_rd_en;
    logic                      err;

    modport master (
        output ts_num4, ts_wr4, ts_wr_en4, mem_rd_cpu_request, mem_rd_addr_cpu,
               dout, dout_valid, err,
        input  ts_rd4, mem_dout, mem_rd_cpu_valid, dout_rd_en
    );

    modport slave (
        input  ts_num4, ts_wr4, ts_wr_en4, mem_rd_cpu_request, mem_rd_addr_cpu,
               dout, dout_valid, err,
        output ts_rd4, mem_dout, mem_rd_cpu_valid, dout_rd_en
    );

endinterface

// File: rtl/engine_result_reader_result_obuf.sv
// result_obuf: 2-entry FIFO whose head entry is the registered output word.
// Only the occupancy counter is reset; data entries hold whatever was last written.
module result_obuf #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [1:0]        free_cnt
);

    logic [1:0]        count;
    logic [DATA_W-1:0] head_p0;
    logic [DATA_W-1:0] tail_p0;
    logic              pop;

    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    assign free_cnt = 2'd2 - count;
    assign pop      = rd_en && !empty;
    assign dout     = head_p0;

    // Occupancy: push and pop together leave the count unchanged.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= 2'd0;
        end else if (push && !pop && !full) begin
            count <= count + 2'd1;
        end else if (pop && !push) begin
            count <= count - 2'd1;
        end
    end

    // Data movement: head is always the oldest word, tail the second oldest.
    always_ff @(posedge CLK) begin
        if (push && !pop) begin
            if (count == 2'd0) begin
                head_p0 <= din;
            end else if (count == 2'd1) begin
                tail_p0 <= din;
            end
        end else if (pop && !push) begin
            head_p0 <= tail_p0;
        end else if (push && pop) begin
            if (count == 2'd1) begin
                head_p0 <= din;
            end else begin
                head_p0 <= tail_p0;
                tail_p0 <= din;
            end
        end
    end

endmodule

// File: rtl/engine_result_reader.sv
// engine_result_reader: scans thread_state channel 4 for finished threads, reads their
// digest words from main memory one request at a time and streams them out, then
// releases the thread back to THREAD_STATE_NONE.
// Optional feature: define RESULT_HEADER_EN to emit a header word before each result.
module engine_result_reader
    import engine_result_reader_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    engine_result_reader_if.master bus
);

    localparam logic [4:0] LAST_K = 5'(RESULT_WORDS - 1);
    localparam logic [4:0] OFFSET = 5'(RESULT_OFFSET);

    rd_state_t         state, state_nxt;
    thread_num_t       ts_num, ts_num_nxt;
    logic [4:0]        k, k_nxt;
    logic              req_out;
    logic              req_issue;
    logic              err_q;
    logic              ts_wr_en;
    logic              credit;
    logic              obuf_push;
    logic [DATA_W-1:0] obuf_din;
    logic              obuf_full;
    logic              obuf_empty;
    logic [1:0]        obuf_free;

    // A request is only issued while a buffer entry is free, so its returning word always fits.
    assign credit = (obuf_free != 2'd0);

    // ts_num doubles as the latched thread: it is frozen from latch until release.
    always_comb begin
        state_nxt  = state;
        ts_num_nxt = ts_num;
        k_nxt      = k;
        req_issue  = 1'b0;
        ts_wr_en   = 1'b0;
        obuf_push  = 1'b0;
        obuf_din   = bus.mem_dout;
        case (state)
            ST_SCAN: begin
                if (bus.ts_rd4 == THREAD_STATE_RD_RDY) begin
                    k_nxt = '0;
`ifdef RESULT_HEADER_EN
                    state_nxt = ST_HDR;
`else
                    state_nxt = ST_RD;
`endif
                end else begin
                    ts_num_nxt = next_thread(ts_num);
                end
            end
            ST_HDR: begin
                if (credit) begin
                    obuf_push = 1'b1;
                    obuf_din  = header_word(ts_num);
                    state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                req_issue = !RST && !req_out && credit;
                if (bus.mem_rd_cpu_valid && req_out) begin
                    obuf_push = 1'b1;
                    if (k == LAST_K) begin
                        state_nxt = ST_RELEASE;
                    end else begin
                        k_nxt = k + 5'd1;
                    end
                end
            end
            ST_RELEASE: begin
                ts_wr_en   = 1'b1;
                ts_num_nxt = next_thread(ts_num);
                state_nxt  = ST_SCAN;
            end
            default: state_nxt = ST_SCAN;
        endcase
    end

    // Control state, outstanding-request flag and sticky protocol error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_SCAN;
            ts_num  <= '0;
            k       <= '0;
            req_out <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ts_num <= ts_num_nxt;
            k      <= k_nxt;
            if (req_issue) begin
                req_out <= 1'b1;
            end else if (bus.mem_rd_cpu_valid) begin
                req_out <= 1'b0;
            end
            if ((bus.mem_rd_cpu_valid && !req_out) ||
                (state == ST_RD && bus.ts_rd4 != THREAD_STATE_RD_RDY)) begin
                err_q <= 1'b1;
            end
        end
    end

    // The credit rule guarantees a push never lands on a full buffer that is not popping.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(obuf_push && obuf_full && !(bus.dout_rd_en && !obuf_empty)));
        end
    end

    result_obuf #(.DATA_W(DATA_W)) u_obuf (
        .CLK      (CLK),
        .RST      (RST),
        .push     (obuf_push),
        .din      (obuf_din),
        .rd_en    (bus.dout_rd_en),
        .dout     (bus.dout),
        .full     (obuf_full),
        .empty    (obuf_empty),
        .free_cnt (obuf_free)
    );

    assign bus.ts_num4            = ts_num;
    assign bus.ts_wr4             = THREAD_STATE_NONE;
    assign bus.ts_wr_en4          = ts_wr_en;
    assign bus.mem_rd_cpu_request = req_issue;
    assign bus.mem_rd_addr_cpu    = {ts_num, OFFSET + k};
    assign bus.dout_valid         = !obuf_empty;
    assign bus.err                = err_q;

endmodule

// File: tb/tb_engine_result_reader.sv
// Bench for engine_result_reader: thread-state array and variable-latency memory model,
// scoreboard queue filled by the stimulus and drained by an output monitor.
module tb_engine_result_reader;
    import engine_result_reader_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    engine_result_reader_if bus();

    engine_result_reader dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [THREAD_STATE_MSB:0] ts [N_THREADS] = '{default: THREAD_STATE_NONE};
    logic [N_THREADS-1:0]      rdy_set = '0;
    logic [DATA_W-1:0]         mem [2**(MEM_TOTAL_MSB+1)];
    int                        lat = 1;
    logic                      model_vld = 1'b0;
    logic                      inject = 1'b0;
    logic                      pend = 1'b0;
    int                        cnt = 0;
    logic [MEM_TOTAL_MSB:0]    addr_q = '0;
    logic [DATA_W-1:0]         model_dout = '0;
    int                        req_cnt = 0;
    thread_num_t               rel_q [$];
    logic                      dout_rd_en = 1'b1;

    int                        checks = 0;
    int                        failures = 0;
    int                        rx_cnt = 0;
    logic [DATA_W-1:0]         exp_q [$];

    assign bus.ts_rd4           = ts[bus.ts_num4];
    assign bus.mem_dout         = model_dout;
    assign bus.mem_rd_cpu_valid = model_vld | inject;
    assign bus.dout_rd_en       = dout_rd_en;

    // Thread-state storage and memory read port with programmable latency.
    always @(posedge CLK) begin
        model_vld <= 1'b0;
        if (bus.ts_wr_en4) begin
            ts[bus.ts_num4] <= bus.ts_wr4;
            rel_q.push_back(bus.ts_num4);
        end
        for (int i = 0; i < N_THREADS; i++) begin
            if (rdy_set[i]) ts[i] <= THREAD_STATE_RD_RDY;
        end
        if (RST) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                if (cnt == 0) begin
                    model_vld  <= 1'b1;
                    model_dout <= mem[addr_q];
                    pend       <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (bus.mem_rd_cpu_request) begin
                pend    <= 1'b1;
                addr_q  <= bus.mem_rd_addr_cpu;
                cnt     <= lat - 1;
                req_cnt <= req_cnt + 1;
            end
        end
    end

    function automatic logic [DATA_W-1:0] exp_word(int t, int i);
        if (t == 3) return 32'h1000 + 32'(i);
        return {8'hA0, 8'(t), 16'(i)};
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_result(int t);
        for (int i = 0; i < RESULT_WORDS; i++) exp_q.push_back(exp_word(t, i));
    endtask

    task automatic set_rdy(logic [N_THREADS-1:0] mask);
        rdy_set = mask;
        tick(1);
        rdy_set = '0;
    endtask

    task automatic wait_rx(string name, int target, int budget);
        int n = 0;
        while (rx_cnt < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (rx_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL %s timeout got=%0d words exp=%0d", name, rx_cnt, target);
        end
    endtask

    task automatic expect_release(string name, int t);
        logic [31:0] got = 32'hFFFF_FFFF;
        if (rel_q.size() != 0) got = 32'(rel_q.pop_front());
        check(name, got, 32'(t));
        check({name, "_ts"}, 32'(ts[t]), 32'(THREAD_STATE_NONE));
    endtask

    initial begin
        int base;
        int rbase;
        int r0;
        int n;

        for (int t = 0; t < N_THREADS; t++)
            for (int w = 0; w < 32; w++)
                mem[t*32 + w] = (t == 3) ? 32'h1000 + 32'(w) : {8'hA0, 8'(t), 16'(w)};

        fork
            // Output monitor: every accepted word is compared with the scoreboard head.
            forever begin
                @(negedge CLK);
                if (!RST && bus.dout_valid && dout_rd_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL dout_unexpected got=%h exp=none", bus.dout);
                    end else begin
                        logic [31:0] e;
                        e = exp_q.pop_front();
                        if (bus.dout !== e) begin
                            failures++;
                            $display("FAIL dout_word got=%h exp=%h", bus.dout, e);
                        end
                    end
                    rx_cnt++;
                end
            end
        join_none

        // Reset values
        tick(3);
        @(negedge CLK);
        check("rst_ts_num4", 32'(bus.ts_num4), 0);
        check("rst_ts_wr_en4", 32'(bus.ts_wr_en4), 0);
        check("rst_request", 32'(bus.mem_rd_cpu_request), 0);
        check("rst_dout_valid", 32'(bus.dout_valid), 0);
        check("rst_err", 32'(bus.err), 0);
        tick(1);
        RST = 1'b0;

        // Test 1: thread 3, words 0x1000..0x1007
        lat = 1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h1000 + 32'(i));
        base = rx_cnt;
        set_rdy(N_THREADS'(1) << 3);
        wait_rx("t1_words", base + 8, 300);
        tick(3);
        @(negedge CLK);
        expect_release("t1_release", 3);
        check("t1_err", 32'(bus.err), 0);
        tick(1);

        // Test 2: threads N-1 and 0, served in wrap order
        lat = 2;
        n = 0;
        while (32'(bus.ts_num4) != 2 && n < 40) begin
            tick(1);
            n++;
        end
        push_result(N_THREADS - 1);
        push_result(0);
        base = rx_cnt;
        set_rdy((N_THREADS'(1) << (N_THREADS - 1)) | N_THREADS'(1));
        wait_rx("t2_words", base + 16, 600);
        tick(3);
        @(negedge CLK);
        expect_release("t2_release_first", N_THREADS - 1);
        expect_release("t2_release_second", 0);
        check("t2_err", 32'(bus.err), 0);
        tick(1);

        // Test 3: consumer stall mid-result
        lat = 1;
        push_result(2);
        base = rx_cnt;
        rbase = req_cnt;
        set_rdy(N_THREADS'(1) << 2);
        wait_rx("t3_first", base + 2, 200);
        tick(1);
        dout_rd_en = 1'b0;
        tick(10);
        r0 = req_cnt;
        tick(40);
        @(negedge CLK);
        check("t3_no_requests", 32'(req_cnt), 32'(r0));
        check("t3_buffered", 32'((req_cnt - rbase) - (rx_cnt - base)), 2);
        check("t3_dout_valid", 32'(bus.dout_valid), 1);
        tick(1);
        dout_rd_en = 1'b1;
        wait_rx("t3_rest", base + 8, 300);
        tick(3);
        @(negedge CLK);
        expect_release("t3_release", 2);
        check("t3_err", 32'(bus.err), 0);
        tick(1);

        // Test 4: reset after 4 words of thread 5, then full re-read
        lat = 3;
        push_result(5);
        base = rx_cnt;
        set_rdy(N_THREADS'(1) << 5);
        wait_rx("t4_first", base + 4, 300);
        tick(1);
        RST = 1'b1;
        exp_q.delete();
        push_result(5);
        tick(2);
        @(negedge CLK);
        check("t4_rst_dout_valid", 32'(bus.dout_valid), 0);
        check("t4_rst_request", 32'(bus.mem_rd_cpu_request), 0);
        check("t4_rst_ts_wr_en4", 32'(bus.ts_wr_en4), 0);
        check("t4_rst_ts_num4", 32'(bus.ts_num4), 0);
        check("t4_rst_err", 32'(bus.err), 0);
        check("t4_thread5_state", 32'(ts[5]), 32'(THREAD_STATE_RD_RDY));
        check("t4_no_release", 32'(rel_q.size()), 0);
        tick(1);
        RST = 1'b0;
        base = rx_cnt;
        wait_rx("t4_reread", base + 8, 400);
        tick(4);
        @(negedge CLK);
        expect_release("t4_release", 5);
        check("t4_err", 32'(bus.err), 0);
        tick(1);

        // Test 5: spurious read-valid while scanning
        inject = 1'b1;
        tick(1);
        inject = 1'b0;
        @(negedge CLK);
        check("t5_err_set", 32'(bus.err), 1);
        tick(10);
        @(negedge CLK);
        check("t5_err_sticky", 32'(bus.err), 1);
        tick(1);
        RST = 1'b1;
        tick(2);
        @(negedge CLK);
        check("t5_err_cleared", 32'(bus.err), 0);
        tick(1);
        RST = 1'b0;

`ifdef RESULT_HEADER_EN
        // Test 6: header word precedes the data words
        lat = 1;
        exp_q.push_back(32'h0008_0007);
        push_result(7);
        base = rx_cnt;
        set_rdy(N_THREADS'(1) << 7);
        wait_rx("t6_words", base + 9, 300);
        tick(3);
        @(negedge CLK);
        expect_release("t6_release", 7);
        tick(1);
`endif

        @(negedge CLK);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
